// File: rtl/kb_scr_fifo_drv_pkg.sv
// Shared definitions for the keyboard/screen FIFO driver.
// Holds the CSR bit positions, which the CPU decode logic also uses.
// Also holds a helper that packs a CSR byte and a helper that applies
// a CSR write to the control bits.
package kb_scr_fifo_drv_pkg;

  // CSR bit map: {3'b0, ena, of, dba, io, ie}
  localparam int CSR_ENA = 4;
  localparam int CSR_OF  = 3;
  localparam int CSR_DBA = 2;
  localparam int CSR_IO  = 1;
  localparam int CSR_IE  = 0;

  // Writable/sticky part of a channel CSR. dba and io are not stored
  // here: dba comes from the FIFO count and io is a per-channel constant.
  typedef struct packed {
    logic ena;
    logic of;
    logic ie;
  } csr_ctl_t;

  function automatic logic [7:0] pack_csr(input csr_ctl_t c, input logic dba,
                                          input logic io);
    logic [7:0] r;
    r          = 8'h00;
    r[CSR_ENA] = c.ena;
    r[CSR_OF]  = c.of;
    r[CSR_DBA] = dba;
    r[CSR_IO]  = io;
    r[CSR_IE]  = c.ie;
    return r;
  endfunction

  // ena and ie load on a write.
  // Writing 0 to of clears it, and writing 1 leaves it alone.
  // A same-cycle overflow event takes priority over a clear.
  function automatic csr_ctl_t csr_update(input csr_ctl_t cur, input logic wr,
                                          input logic [7:0] d,
                                          input logic of_set);
    csr_ctl_t n;
    n    = cur;
    if (wr) begin
      n.ena = d[CSR_ENA];
      n.ie  = d[CSR_IE];
      if (!d[CSR_OF]) n.of = 1'b0;
    end
    if (of_set) n.of = 1'b1;
    return n;
  endfunction

endpackage

// File: rtl/kb_scr_fifo_drv_if.sv
// Bus bundle for kb_scr_fifo_drv: keyboard device, screen device and CPU side.
//   slave  : view used by the driver
//   master : view used by whoever drives the devices/CPU (e.g. a bench)
// Signals:
//   kb_dev_data_i/valid_i/ready_o   keyboard device handshake
//   scr_dev_data_o/valid_o/ready_i  screen device handshake
//   kb_data_o, kb_rd_i              CPU reads the keyboard FIFO head
//   scr_data_i, scr_wr_i            CPU writes into the screen FIFO
//   csr_data_i, kb/scr_csr_wr_i     CPU CSR writes
//   kb/scr_csr_o, kb/scr_irq_o      status and interrupt levels
interface kb_scr_fifo_drv_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] kb_dev_data_i;
  logic              kb_dev_valid_i;
  logic              kb_dev_ready_o;
  logic [DATA_W-1:0] scr_dev_data_o;
  logic              scr_dev_valid_o;
  logic              scr_dev_ready_i;
  logic [DATA_W-1:0] kb_data_o;
  logic              kb_rd_i;
  logic [DATA_W-1:0] scr_data_i;
  logic              scr_wr_i;
  logic [7:0]        csr_data_i;
  logic              kb_csr_wr_i;
  logic              scr_csr_wr_i;
  logic [7:0]        kb_csr_o;
  logic [7:0]        scr_csr_o;
  logic              kb_irq_o;
  logic              scr_irq_o;

  modport slave (
    input  kb_dev_data_i, kb_dev_valid_i, scr_dev_ready_i, kb_rd_i,
           scr_data_i, scr_wr_i, csr_data_i, kb_csr_wr_i, scr_csr_wr_i,
    output kb_dev_ready_o, scr_dev_data_o, scr_dev_valid_o, kb_data_o,
           kb_csr_o, scr_csr_o, kb_irq_o, scr_irq_o
  );

  modport master (
    output kb_dev_data_i, kb_dev_valid_i, scr_dev_ready_i, kb_rd_i,
           scr_data_i, scr_wr_i, csr_data_i, kb_csr_wr_i, scr_csr_wr_i,
    input  kb_dev_ready_o, scr_dev_data_o, scr_dev_valid_o, kb_data_o,
           kb_csr_o, scr_csr_o, kb_irq_o, scr_irq_o
  );
endinterface

// File: rtl/kb_scr_fifo_drv_sync_fifo.sv
// sync_fifo: single-clock FIFO with zero read latency (dout is the head entry).
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (empties the FIFO)
//   push, din    write request and data; when full, it is taken only with a pop
//   pop          remove the head; it is ignored when the FIFO is empty
//   dout         head entry; it is undefined while empty
//   full, empty  decoded from the registered count
//   count        number of entries, 0..DEPTH
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a write in the same cycle that it frees a slot.
  assign do_push = push & (~full | do_pop);

  // The storage is not reset. The count and the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of 2, so the pointers wrap naturally.
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/kb_scr_fifo_drv.sv
// kb_scr_fifo_drv: keyboard/screen device driver with FIFOs on both channels.
//   Keyboard: bytes from the device are buffered for the CPU to read.
//   Screen: CPU bytes are buffered and then drained to the device.
//   Each channel has a CSR {3'b0, ena, of, dba, io, ie} and a level interrupt (ie & dba).
// Ports:
//   clk    single clock, posedge
//   rst_n  synchronous active-low reset
//   bus    kb_scr_fifo_drv_if.slave (device handshakes, CPU access, CSRs, irqs)
module kb_scr_fifo_drv
  import kb_scr_fifo_drv_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int KB_DEPTH  = 4,
  parameter int SCR_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  kb_scr_fifo_drv_if.slave     bus
);
  localparam int KB_AW  = $clog2(KB_DEPTH);
  localparam int SCR_AW = $clog2(SCR_DEPTH);
  localparam logic [SCR_AW:0] SCR_CNT_FULL = (SCR_AW+1)'(SCR_DEPTH);

  csr_ctl_t          kb_ctl_reg,  kb_ctl_next;
  csr_ctl_t          scr_ctl_reg, scr_ctl_next;

  logic [DATA_W-1:0] kb_dout,  scr_dout;
  logic              kb_full,  kb_empty;
  logic              scr_full, scr_empty;
  logic [KB_AW:0]    kb_count;
  logic [SCR_AW:0]   scr_count;

  logic              kb_push, kb_pop, kb_of_set, kb_dba;
  logic              scr_push, scr_pop, scr_of_set, scr_dba;

  // ---------------- keyboard channel ----------------
  // ready depends only on registered state. A full FIFO refuses the device
  // even when the CPU pops in the same cycle.
  assign bus.kb_dev_ready_o = kb_ctl_reg.ena & ~kb_full;
  assign kb_push   = bus.kb_dev_valid_i & bus.kb_dev_ready_o;
  assign kb_pop    = bus.kb_rd_i & ~kb_empty;
  assign kb_of_set = bus.kb_dev_valid_i & kb_ctl_reg.ena & kb_full;
  assign kb_dba    = (kb_count != '0);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(KB_DEPTH)) u_kb_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (kb_push),
    .pop   (kb_pop),
    .din   (bus.kb_dev_data_i),
    .dout  (kb_dout),
    .full  (kb_full),
    .empty (kb_empty),
    .count (kb_count)
  );

  assign bus.kb_data_o = kb_empty ? '0 : kb_dout;

  // ---------------- screen channel ----------------
  assign bus.scr_dev_valid_o = scr_ctl_reg.ena & ~scr_empty;
  assign scr_pop    = bus.scr_dev_valid_o & bus.scr_dev_ready_i;
  // The CPU may write regardless of ena. A full FIFO still accepts the write
  // when the device drains an entry in the same cycle.
  assign scr_push   = bus.scr_wr_i & (~scr_full | scr_pop);
  assign scr_of_set = bus.scr_wr_i & scr_full & ~scr_pop;
  assign scr_dba    = (scr_count != SCR_CNT_FULL);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(SCR_DEPTH)) u_scr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (scr_push),
    .pop   (scr_pop),
    .din   (bus.scr_data_i),
    .dout  (scr_dout),
    .full  (scr_full),
    .empty (scr_empty),
    .count (scr_count)
  );

  // Drive zero while empty so the uninitialised storage never shows on the output.
  assign bus.scr_dev_data_o = scr_empty ? '0 : scr_dout;

  // ---------------- CSRs and interrupts ----------------
  always_comb begin
    kb_ctl_next  = csr_update(kb_ctl_reg,  bus.kb_csr_wr_i,  bus.csr_data_i, kb_of_set);
    scr_ctl_next = csr_update(scr_ctl_reg, bus.scr_csr_wr_i, bus.csr_data_i, scr_of_set);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_ctl_reg  <= '0;
      scr_ctl_reg <= '0;
    end else begin
      kb_ctl_reg  <= kb_ctl_next;
      scr_ctl_reg <= scr_ctl_next;
    end
  end

  assign bus.kb_csr_o  = pack_csr(kb_ctl_reg,  kb_dba,  1'b0);
  assign bus.scr_csr_o = pack_csr(scr_ctl_reg, scr_dba, 1'b1);
  assign bus.kb_irq_o  = kb_ctl_reg.ie  & kb_dba;
  assign bus.scr_irq_o = scr_ctl_reg.ie & scr_dba;

endmodule

// File: tb/tb_kb_scr_fifo_drv.sv
// Self-checking bench for kb_scr_fifo_drv.
// The reference model keeps each FIFO as a queue and each CSR as plain bits.
// Every cycle the model predicts the DUT outputs, and the bench checks them.
module tb_kb_scr_fifo_drv;
  localparam int KB_DEPTH  = 4;
  localparam int SCR_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kb_scr_fifo_drv_if #(.DATA_W(8)) bus ();

  kb_scr_fifo_drv #(.DATA_W(8), .KB_DEPTH(KB_DEPTH), .SCR_DEPTH(SCR_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] kb_q[$];
  logic [7:0] scr_q[$];
  bit kb_ena, kb_of, kb_ie;
  bit scr_ena, scr_of, scr_ie;

  // stimulus for the next clock edge
  bit         s_rst, s_kv, s_krd, s_swr, s_srdy, s_kcw, s_scw;
  logic [7:0] s_kd, s_sd, s_cd;

  task automatic clear_stim();
    s_rst = 0; s_kv = 0; s_krd = 0; s_swr = 0; s_srdy = 0; s_kcw = 0; s_scw = 0;
    s_kd = '0; s_sd = '0; s_cd = '0;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_kb_data, exp_scr_data, exp_kb_csr, exp_scr_csr;
    bit kb_ne, scr_nf, scr_ne;
    kb_ne  = kb_q.size() > 0;
    scr_ne = scr_q.size() > 0;
    scr_nf = scr_q.size() < SCR_DEPTH;
    exp_kb_data  = kb_ne  ? kb_q[0]  : 8'h00;
    exp_scr_data = scr_ne ? scr_q[0] : 8'h00;
    exp_kb_csr   = {3'b000, kb_ena,  kb_of,  kb_ne,  1'b0, kb_ie};
    exp_scr_csr  = {3'b000, scr_ena, scr_of, scr_nf, 1'b1, scr_ie};
    check("kb_ready",  32'(bus.kb_dev_ready_o),  32'(kb_ena && kb_q.size() < KB_DEPTH));
    check("kb_data",   32'(bus.kb_data_o),       32'(exp_kb_data));
    check("kb_csr",    32'(bus.kb_csr_o),        32'(exp_kb_csr));
    check("kb_irq",    32'(bus.kb_irq_o),        32'(kb_ie && kb_ne));
    check("scr_valid", 32'(bus.scr_dev_valid_o), 32'(scr_ena && scr_ne));
    check("scr_data",  32'(bus.scr_dev_data_o),  32'(exp_scr_data));
    check("scr_csr",   32'(bus.scr_csr_o),       32'(exp_scr_csr));
    check("scr_irq",   32'(bus.scr_irq_o),       32'(scr_ie && scr_nf));
  endtask

  // Apply the stimulus for one clock and advance the model in the same way.
  task automatic step();
    int  ksz, ssz;
    bit  k_rdy, k_of_set, s_pop, s_acc, s_of_set;
    bus.kb_dev_data_i  = s_kd;
    bus.kb_dev_valid_i = s_kv;
    bus.kb_rd_i        = s_krd;
    bus.scr_data_i     = s_sd;
    bus.scr_wr_i       = s_swr;
    bus.scr_dev_ready_i = s_srdy;
    bus.csr_data_i     = s_cd;
    bus.kb_csr_wr_i    = s_kcw;
    bus.scr_csr_wr_i   = s_scw;
    rst_n              = ~s_rst;

    if (s_rst) begin
      kb_q.delete(); scr_q.delete();
      kb_ena = 0; kb_of = 0; kb_ie = 0;
      scr_ena = 0; scr_of = 0; scr_ie = 0;
    end else begin
      ksz      = kb_q.size();
      k_rdy    = kb_ena && ksz < KB_DEPTH;
      k_of_set = s_kv && kb_ena && ksz == KB_DEPTH;
      if (s_krd && ksz > 0) void'(kb_q.pop_front());
      if (s_kv && k_rdy) kb_q.push_back(s_kd);

      ssz      = scr_q.size();
      s_pop    = scr_ena && ssz > 0 && s_srdy;
      s_acc    = ssz < SCR_DEPTH || s_pop;
      s_of_set = s_swr && !s_acc;
      if (s_pop) void'(scr_q.pop_front());
      if (s_swr && s_acc) scr_q.push_back(s_sd);

      if (s_kcw) begin
        kb_ena = s_cd[4]; kb_ie = s_cd[0];
        if (!s_cd[3]) kb_of = 0;
      end
      if (k_of_set) kb_of = 1;
      if (s_scw) begin
        scr_ena = s_cd[4]; scr_ie = s_cd[0];
        if (!s_cd[3]) scr_of = 0;
      end
      if (s_of_set) scr_of = 1;
    end

    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    $display("cyc %0d rst=%0b kv=%0b krd=%0b swr=%0b srdy=%0b | kb_n=%0d scr_n=%0d kb_csr=%02h scr_csr=%02h",
             cyc, s_rst, s_kv, s_krd, s_swr, s_srdy, kb_q.size(), scr_q.size(),
             bus.kb_csr_o, bus.scr_csr_o);
    clear_stim();
  endtask

  task automatic idle();             clear_stim();                         step(); endtask
  task automatic do_reset();         clear_stim(); s_rst = 1;              step(); endtask
  task automatic kb_push(input logic [7:0] d);  clear_stim(); s_kv = 1; s_kd = d; step(); endtask
  task automatic kb_pop();           clear_stim(); s_krd = 1;              step(); endtask
  task automatic cpu_wr(input logic [7:0] d);   clear_stim(); s_swr = 1; s_sd = d; step(); endtask
  task automatic kb_csr(input logic [7:0] d);   clear_stim(); s_kcw = 1; s_cd = d; step(); endtask
  task automatic scr_csr(input logic [7:0] d);  clear_stim(); s_scw = 1; s_cd = d; step(); endtask

  initial begin
    clear_stim();
    bus.kb_dev_data_i = '0; bus.kb_dev_valid_i = 0; bus.kb_rd_i = 0;
    bus.scr_data_i = '0; bus.scr_wr_i = 0; bus.scr_dev_ready_i = 0;
    bus.csr_data_i = '0; bus.kb_csr_wr_i = 0; bus.scr_csr_wr_i = 0;

    // 1: reset values
    do_reset(); do_reset();
    check("rst_kb_csr",  32'(bus.kb_csr_o),  32'h00);
    check("rst_scr_csr", 32'(bus.scr_csr_o), 32'h06);
    idle();

    // 2: kb ena+ie, two bytes, two pops
    kb_csr(8'h11);
    kb_push(8'h41); kb_push(8'h42); idle();
    kb_pop(); kb_pop(); idle();

    // 3: overflow on the fifth byte, sticky of, set wins over clear
    for (int i = 0; i < 5; i++) kb_push(8'h50 + 8'(i));
    kb_csr(8'h19);                                   // of written 1: no effect
    clear_stim(); s_kv = 1; s_kd = 8'h77; s_kcw = 1; s_cd = 8'h11; step(); // set beats clear
    kb_csr(8'h11);                                   // clear of
    clear_stim(); s_kv = 1; s_kd = 8'h78; s_krd = 1; step(); // full: pop only, no push
    for (int i = 0; i < 4; i++) kb_pop();
    kb_pop();                                        // pop while empty ignored
    kb_csr(8'h00);
    kb_push(8'h99);                                  // ena=0: ignored

    // 4: scr writes with ena=0, overflow, then drain
    for (int i = 0; i < 5; i++) cpu_wr(8'h10 + 8'(i));
    scr_csr(8'h11);
    for (int i = 0; i < 5; i++) begin
      clear_stim(); s_srdy = 1; step();
    end

    // 5: scr full, ready toggling, CPU writes on pop cycles
    scr_csr(8'h01);
    for (int i = 0; i < 4; i++) cpu_wr(8'h20 + 8'(i));
    scr_csr(8'h11);
    for (int i = 0; i < 12; i++) begin
      clear_stim(); s_srdy = (i % 2 == 0); s_swr = s_srdy; s_sd = 8'h30 + 8'(i); step();
    end
    // ena 1->0 mid-stream: contents held, resume later
    scr_csr(8'h01);
    clear_stim(); s_srdy = 1; step();
    scr_csr(8'h11);
    for (int i = 0; i < 6; i++) begin
      clear_stim(); s_srdy = 1; step();
    end

    // 6: reset with both FIFOs half full
    kb_csr(8'h11); kb_push(8'hA1); kb_push(8'hA2);
    scr_csr(8'h00); cpu_wr(8'hB1); cpu_wr(8'hB2);
    do_reset();
    check("rst6_kb_csr",  32'(bus.kb_csr_o),  32'h00);
    check("rst6_scr_csr", 32'(bus.scr_csr_o), 32'h06);
    check("rst6_kb_data", 32'(bus.kb_data_o), 32'h00);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      clear_stim();
      s_rst  = ($urandom_range(0, 99) == 0);
      s_kv   = ($urandom_range(0, 99) < 50);
      s_kd   = 8'($urandom);
      s_krd  = ($urandom_range(0, 99) < 35);
      s_swr  = ($urandom_range(0, 99) < 45);
      s_sd   = 8'($urandom);
      s_srdy = ($urandom_range(0, 99) < 40);
      s_kcw  = ($urandom_range(0, 99) < 8);
      s_scw  = ($urandom_range(0, 99) < 8);
      s_cd   = 8'($urandom);
      // mostly keep channels enabled so the FIFOs actually move
      if ($urandom_range(0, 3) != 0) s_cd[4] = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
